// File: rtl/debouncer.sv
// Push-button debouncer with an integrated sample-rate divider.
// A raw button input is synchronised, sampled on a divided clock-enable strobe,
// and only accepted once STABLE_CNT consecutive samples agree.
// Optional feature macro: DEBOUNCER_EDGE_EN builds the pb_rise/pb_fall
// one-cycle edge pulses; when undefined both outputs are tied to 0.
module debouncer #(
  parameter int SAMPLE_DIV = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pb_in,
  output logic pb_out,
  output logic pb_rise,
  output logic pb_fall,
  output logic sample_tick
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RUN_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s2;
  logic [DIV_W-1:0] div_cnt;
  logic             last_sample;
  logic [RUN_W-1:0] run_cnt;
  logic             last_next;
  logic [RUN_W-1:0] run_next;
  logic             pb_out_next;

  // Two-flop synchroniser; only s2 is ever looked at by the debounce logic.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pb_in;
      s2 <= s1;
    end
  end

  // Free-running divider; the strobe is registered so it lands one cycle after the terminal count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
      sample_tick <= (div_cnt == DIV_MAX);
    end
  end

  // Run-length tracking: a differing sample restarts the run, an equal one extends it
  // (saturating), and the output follows on the sample that completes the run.
  always_comb begin
    last_next   = last_sample;
    run_next    = run_cnt;
    pb_out_next = pb_out;
    if (sample_tick) begin
      if (s2 != last_sample) begin
        last_next = s2;
        run_next  = '0;
      end else if (run_cnt != RUN_MAX) begin
        run_next = run_cnt + RUN_W'(1);
        if (run_cnt == RUN_MAX - RUN_W'(1)) begin
          pb_out_next = s2;
        end
      end
    end
  end

  // Debounce state registers; reset discards any partially accumulated run.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_sample <= 1'b0;
      run_cnt     <= '0;
      pb_out      <= 1'b0;
    end else begin
      last_sample <= last_next;
      run_cnt     <= run_next;
      pb_out      <= pb_out_next;
    end
  end

`ifdef DEBOUNCER_EDGE_EN
  // Edge pulses are registered alongside pb_out so each is high for the first cycle of the new level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pb_rise <= 1'b0;
      pb_fall <= 1'b0;
    end else begin
      pb_rise <= pb_out_next & ~pb_out;
      pb_fall <= ~pb_out_next & pb_out;
    end
  end
`else
  assign pb_rise = 1'b0;
  assign pb_fall = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: stimulus pushes expected pb_out changes
// (level and exact cycle) into a queue; a negedge monitor pops them whenever
// pb_out changes and also checks the strobe schedule and pulse quietness.
module tb_debouncer;

`ifdef DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic pb_in;
  logic pb_out;
  logic pb_rise;
  logic pb_fall;
  logic sample_tick;

  typedef struct {
    logic level;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rel = 0;
  logic prev_out = 1'b0;

  debouncer #(.SAMPLE_DIV(4), .STABLE_CNT(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pb_in      (pb_in),
    .pb_out     (pb_out),
    .pb_rise    (pb_rise),
    .pb_fall    (pb_fall),
    .sample_tick(sample_tick)
  );

  always #5 Clk = ~Clk;

  // Clock edges counted since reset release.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) rel <= 0;
    else        rel <= rel + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at rel=%0d t=%0t", name, act, exp, rel, $time);
    end
  endtask

  // Edge at which pb_out adopts a level stepped onto pb_in right after edge n:
  // s2 holds it from edge n+2, sampling edges are 5,9,13,...; three samples needed.
  function automatic int change_edge(input int n);
    int m;
    m = n + 3;
    while ((m % 4) != 1) m++;
    return m + 8;
  endfunction

  task automatic step(input logic v, input bit expect_change);
    exp_t e;
    @(posedge Clk);
    #1;
    pb_in = v;
    if (expect_change) begin
      e.level = v;
      e.cyc   = change_edge(rel);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(posedge Clk);
  endtask

  task automatic assert_reset_now();
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("reset_async_out", {28'd0, pb_out, pb_rise, pb_fall, sample_tick}, 32'd0);
  endtask

  // Monitor: checks strobe schedule every cycle, and pops the scoreboard on each pb_out change.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      chk("reset_out", {28'd0, pb_out, pb_rise, pb_fall, sample_tick}, 32'd0);
      prev_out = 1'b0;
    end else begin
      chk("sample_tick", {31'd0, sample_tick}, {31'd0, (rel >= 4) && ((rel % 4) == 0)});
      if (pb_out !== prev_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", {31'd0, pb_out}, {31'd0, prev_out});
        end else begin
          e = exp_q.pop_front();
          chk("change_level", {31'd0, pb_out}, {31'd0, e.level});
          chk("change_cycle", rel, e.cyc);
          chk("pb_rise_on_change", {31'd0, pb_rise}, {31'd0, EDGE_EN & e.level});
          chk("pb_fall_on_change", {31'd0, pb_fall}, {31'd0, EDGE_EN & ~e.level});
        end
      end else begin
        chk("pulses_quiet", {30'd0, pb_rise, pb_fall}, 32'd0);
      end
      prev_out = pb_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    pb_in = 1'b1;
    // Reset held with the button pressed: everything must stay 0.
    wait_clk(5);
    pb_in = 1'b0;
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    // Idle at 0: strobes every 4 clocks, no output activity.
    wait_clk(40);
    // Bouncing: two samples per level never complete a run.
    for (int i = 0; i < 30; i++) begin
      step(~pb_in, 1'b0);
      wait_clk(7);
    end
    // Clean press, then clean release.
    step(1'b1, 1'b1);
    wait_clk(40);
    step(1'b0, 1'b1);
    wait_clk(20);
    // Press again, then reset while pb_out is high.
    step(1'b1, 1'b1);
    wait_clk(40);
    chk("pb_out_high_before_reset", {31'd0, pb_out}, 32'd1);
    assert_reset_now();
    wait_clk(3);
    #2;
    Reset = 1'b1;
    begin
      exp_t e;
      e.level = 1'b1;
      e.cyc   = 13;
      exp_q.push_back(e);
    end
    wait_clk(30);
    // Release, then a partial run of 1s interrupted by reset.
    step(1'b0, 1'b1);
    wait_clk(20);
    step(1'b1, 1'b0);
    wait_clk(6);
    assert_reset_now();
    pb_in = 1'b0;
    wait_clk(3);
    #2;
    Reset = 1'b1;
    wait_clk(30);
    step(1'b1, 1'b1);
    wait_clk(20);
    step(1'b0, 1'b1);
    wait_clk(20);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
